// File: rtl/frog_pkg.sv
// Shared definitions for the Frogger game sequencer: state encoding,
// spawn position and the rows that never hold cars.
package frog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_DYING = 3'd2,
    ST_WIN   = 3'd3,
    ST_OVER  = 3'd4
  } game_state_e;

  localparam logic [2:0] START_ROW = 3'd7;
  localparam logic [7:0] START_COL = 8'b0001_0000;

  localparam logic [2:0] GOAL_ROW   = 3'd0;
  localparam logic [2:0] MEDIAN_ROW = 3'd4;

  // Goal, median and start rows have no lane attached, so the frog is always safe there.
  function automatic logic is_safe_row(input logic [2:0] row);
    return (row == GOAL_ROW) || (row == MEDIAN_ROW) || (row == START_ROW);
  endfunction

endpackage

// File: rtl/frog_game_ctrl_btn_debounce.sv
// One button path: 2-flop synchronizer, debounce counter and a one-cycle
// pulse on the debounced press (high-to-low) edge. Buttons are active-low.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept a new level only after it has differed from the current one for the full window; any bounce restarts the count.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Registers come out of reset as "released" so no spurious press fires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/frog_game_ctrl.sv
// Frogger game sequencer: debounced moves, frog position, lives, score,
// lane pacing and the IDLE/PLAY/DYING/WIN/OVER flow.
module frog_game_ctrl
  import frog_pkg::*;
#(
  parameter int TICK_DIV        = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LIVES           = 3,
  parameter int HOLD_TICKS      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic [7:0] vert1,
  input  logic [7:0] vert2,
  input  logic [7:0] vert3,
  input  logic [7:0] vert5,
  input  logic [7:0] vert6,
  output logic       lane_step,
  output logic [2:0] frog_row,
  output logic [7:0] frog_col,
  output logic [2:0] game_state,
  output logic [1:0] lives,
  output logic [7:0] score
);

  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [1:0]        LIVES_INIT = 2'(LIVES);

  game_state_e       state_q, state_d;
  logic [2:0]        row_q, row_d;
  logic [7:0]        col_q, col_d;
  logic [1:0]        lives_q, lives_d;
  logic [7:0]        score_q, score_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              lane_step_q, lane_step_d;

  logic       press_up, press_down, press_left, press_right, any_press;
  logic [7:0] lane_sel;
  logic       hit, active, wrap;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .reset(reset), .btn_n(up), .press(press_up)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .reset(reset), .btn_n(down), .press(press_down)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .reset(reset), .btn_n(left), .press(press_left)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .reset(reset), .btn_n(right), .press(press_right)
  );

  assign any_press = press_up | press_down | press_left | press_right;

  // Pick the lane row under the frog; safe rows see no cars.
  always_comb begin
    lane_sel = 8'h00;
    case (row_q)
      3'd1:    lane_sel = vert1;
      3'd2:    lane_sel = vert2;
      3'd3:    lane_sel = vert3;
      3'd5:    lane_sel = vert5;
      3'd6:    lane_sel = vert6;
      default: lane_sel = 8'h00;
    endcase
  end

  assign hit    = !is_safe_row(row_q) && ((lane_sel & col_q) != 8'h00);
  assign active = (state_q == ST_PLAY) || (state_q == ST_DYING) || (state_q == ST_WIN);
  assign wrap   = active && (tick_q == TICK_LAST);

  // Game flow: tick pacing, moves, collision/goal handling and the timed hold before respawn.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    lives_d = lives_q;
    score_d = score_q;
    hold_d  = hold_q;
    tick_d  = '0;
    if (active) begin
      tick_d = wrap ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (any_press) begin
          state_d = ST_PLAY;
          row_d   = START_ROW;
          col_d   = START_COL;
          lives_d = LIVES_INIT;
          score_d = 8'd0;
        end
      end
      ST_PLAY: begin
        if (hit) begin
          state_d = ST_DYING;
          lives_d = lives_q - 2'd1;
          hold_d  = '0;
        end else if (row_q == GOAL_ROW) begin
          state_d = ST_WIN;
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          hold_d  = '0;
        end else if (press_up) begin
          row_d = row_q - 3'd1;
        end else if (press_down) begin
          if (row_q != START_ROW) row_d = row_q + 3'd1;
        end else if (press_left) begin
          if (!col_q[7]) col_d = col_q << 1;
        end else if (press_right) begin
          if (!col_q[0]) col_d = col_q >> 1;
        end
      end
      ST_DYING, ST_WIN: begin
        if (wrap) begin
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            if ((state_q == ST_DYING) && (lives_q == 2'd0)) begin
              state_d = ST_OVER;
            end else begin
              state_d = ST_PLAY;
              row_d   = START_ROW;
              col_d   = START_COL;
              tick_d  = '0;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      ST_OVER: begin
        if (any_press) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    lane_step_d = wrap && (state_q == ST_PLAY) && (state_d == ST_PLAY);
  end

  // All game state registers; reset returns the board to the idle start picture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      row_q       <= START_ROW;
      col_q       <= START_COL;
      lives_q     <= LIVES_INIT;
      score_q     <= 8'd0;
      tick_q      <= '0;
      hold_q      <= '0;
      lane_step_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      tick_q      <= tick_d;
      hold_q      <= hold_d;
      lane_step_q <= lane_step_d;
    end
  end

  assign lane_step  = lane_step_q;
  assign frog_row   = row_q;
  assign frog_col   = col_q;
  assign game_state = state_q;
  assign lives      = lives_q;
  assign score      = score_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Self-checking bench for frog_game_ctrl: a game-rule model is advanced on
// every clock and compared against the DUT on every falling edge, with
// directed scenarios followed by randomized button/lane traffic.
module tb_frog_game_ctrl;

  localparam int TD = 8;
  localparam int DB = 4;
  localparam int NL = 3;
  localparam int HT = 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       up = 1'b1, down = 1'b1, left = 1'b1, right = 1'b1;
  logic [7:0] vert1 = 8'h00, vert2 = 8'h00, vert3 = 8'h00, vert5 = 8'h00, vert6 = 8'h00;
  logic       lane_step;
  logic [2:0] frog_row;
  logic [7:0] frog_col;
  logic [2:0] game_state;
  logic [1:0] lives;
  logic [7:0] score;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Model state: column kept as a bit index, buttons as a raw-sample history.
  int         m_state, m_row, m_col, m_lives, m_score, m_tick, m_hold;
  bit         m_lane_step;
  logic [3:0] m_hist [0:DB+1];
  logic [3:0] m_level;
  logic [3:0] m_press;

  frog_game_ctrl #(
    .TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .LIVES(NL), .HOLD_TICKS(HT)
  ) dut (
    .clk(clk), .reset(reset),
    .up(up), .down(down), .left(left), .right(right),
    .vert1(vert1), .vert2(vert2), .vert3(vert3), .vert5(vert5), .vert6(vert6),
    .lane_step(lane_step), .frog_row(frog_row), .frog_col(frog_col),
    .game_state(game_state), .lives(lives), .score(score)
  );

  // Free-running 10-unit clock.
  initial forever #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_row = 7; m_col = 4; m_lives = NL; m_score = 0;
    m_tick = 0; m_hold = 0; m_lane_step = 0;
    for (int j = 0; j <= DB + 1; j++) m_hist[j] = 4'hF;
    m_level = 4'hF;
    m_press = 4'h0;
  endtask

  // One clock of game rules; press events used here are those produced on the previous clock.
  task automatic model_step();
    logic [7:0] lane_row [0:7];
    logic [7:0] lr;
    int  nst, nt, nrow, ncol, nlives, nscore, nhold;
    bit  active, wrap, any_evt, all_diff;

    lane_row[0] = 8'h00; lane_row[1] = vert1; lane_row[2] = vert2; lane_row[3] = vert3;
    lane_row[4] = 8'h00; lane_row[5] = vert5; lane_row[6] = vert6; lane_row[7] = 8'h00;

    active  = (m_state >= 1) && (m_state <= 3);
    wrap    = active && (m_tick == TD - 1);
    any_evt = (m_press != 4'h0);
    nst = m_state; nrow = m_row; ncol = m_col; nlives = m_lives; nscore = m_score; nhold = m_hold;
    nt  = active ? (wrap ? 0 : m_tick + 1) : 0;

    case (m_state)
      0: if (any_evt) begin nst = 1; nrow = 7; ncol = 4; nlives = NL; nscore = 0; end
      1: begin
        lr = lane_row[m_row];
        if (lr[m_col]) begin
          nst = 2; nlives = m_lives - 1; nhold = 0;
        end else if (m_row == 0) begin
          nst = 3; nscore = (m_score < 255) ? m_score + 1 : 255; nhold = 0;
        end else if (m_press[3]) begin
          nrow = m_row - 1;
        end else if (m_press[2]) begin
          if (m_row < 7) nrow = m_row + 1;
        end else if (m_press[1]) begin
          if (m_col < 7) ncol = m_col + 1;
        end else if (m_press[0]) begin
          if (m_col > 0) ncol = m_col - 1;
        end
      end
      2, 3: if (wrap) begin
        if (m_hold == HT - 1) begin
          nhold = 0;
          if (m_state == 2 && m_lives == 0) nst = 4;
          else begin nst = 1; nrow = 7; ncol = 4; nt = 0; end
        end else begin
          nhold = m_hold + 1;
        end
      end
      4: if (any_evt) nst = 0;
      default: nst = 0;
    endcase

    m_lane_step = wrap && (m_state == 1) && (nst == 1);
    m_state = nst; m_row = nrow; m_col = ncol; m_lives = nlives;
    m_score = nscore; m_hold = nhold; m_tick = nt;

    // A button level flips once the last DB synchronized samples all disagree with it.
    for (int j = DB + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = {up, down, left, right};
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      for (int j = 2; j <= DB + 1; j++) if (m_hist[j][b] == m_level[b]) all_diff = 1'b0;
      m_press[b] = 1'b0;
      if (all_diff) begin
        m_level[b] = ~m_level[b];
        m_press[b] = (m_level[b] == 1'b0);
      end
    end
  endtask

  // Model follows the same clock and asynchronous reset as the DUT.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // Compare every output against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check_output("game_state", game_state, m_state);
      check_output("frog_row", frog_row, m_row);
      check_output("frog_col", frog_col, 1 << m_col);
      check_output("lives", lives, m_lives);
      check_output("score", score, m_score);
      check_output("lane_step", lane_step, m_lane_step);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mask bits: 3=up 2=down 1=left 0=right; pressed buttons pull low.
  task automatic apply_stimulus(input logic [3:0] mask, input int low_cycles, input int high_cycles);
    @(negedge clk);
    {up, down, left, right} = ~mask;
    wait_cycles(low_cycles);
    {up, down, left, right} = 4'hF;
    wait_cycles(high_cycles);
  endtask

  task automatic press(input logic [3:0] mask);
    apply_stimulus(mask, 7, 7);
  endtask

  task automatic wait_state(input int target, input int budget, input string name);
    int cyc = 0;
    while (int'(game_state) != target && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check_output(name, game_state, target);
  endtask

  task automatic do_win();
    repeat (7) press(4'b1000);
    wait_state(1, 40, "win_respawn");
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_state"}, game_state, 0);
    check_output({tag, "_row"}, frog_row, 7);
    check_output({tag, "_col"}, frog_col, 8'b0001_0000);
    check_output({tag, "_lives"}, lives, 3);
    check_output({tag, "_score"}, score, 0);
    check_output({tag, "_lane_step"}, lane_step, 0);
  endtask

  // Directed scenarios, then randomized traffic.
  initial begin
    int steps;
    int cyc;

    #1 reset = 1'b0;
    wait_cycles(3);
    reset = 1'b1;
    check_reset_values("reset");

    // Bouncing up button, then a clean hold: exactly one event starts the game.
    for (int i = 0; i < 6; i++) begin
      up = (i % 2 == 1);
      wait_cycles(2);
    end
    check_output("bounce_still_idle", game_state, 0);
    up = 1'b0;
    wait_cycles(10);
    up = 1'b1;
    wait_cycles(10);
    check_output("bounce_play", game_state, 1);
    check_output("bounce_row", frog_row, 7);
    check_output("bounce_col", frog_col, 8'b0001_0000);

    steps = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (lane_step) steps++;
    end
    check_output("lane_step_rate", steps, 4);

    // Board edges.
    press(4'b0100);
    check_output("down_at_bottom", frog_row, 7);
    repeat (3) press(4'b0010);
    check_output("left_x3", frog_col, 8'b1000_0000);
    press(4'b0010);
    check_output("left_at_edge", frog_col, 8'b1000_0000);
    repeat (3) press(4'b0001);
    check_output("right_x3", frog_col, 8'b0001_0000);

    // Collision on row 1.
    vert1 = 8'b0111_0111;
    repeat (6) press(4'b1000);
    check_output("collision_state", game_state, 2);
    check_output("collision_lives", lives, 2);
    steps = 0;
    cyc = 0;
    while (game_state != 3'd1 && cyc < 40) begin
      @(negedge clk);
      if (lane_step) steps++;
      cyc++;
    end
    check_output("dying_lane_steps", steps, 0);
    check_output("dying_to_play", game_state, 1);
    check_output("respawn_row", frog_row, 7);
    check_output("respawn_col", frog_col, 8'b0001_0000);
    vert1 = 8'h00;

    // Two more collisions empty the lives and end the game.
    vert6 = 8'hFF;
    press(4'b1000);
    check_output("collision2_lives", lives, 1);
    wait_state(1, 40, "collision2_respawn");
    press(4'b1000);
    check_output("collision3_lives", lives, 0);
    wait_state(4, 40, "game_over");
    check_output("over_lives", lives, 0);
    vert6 = 8'h00;
    press(4'b0001);
    check_output("over_to_idle", game_state, 0);
    press(4'b1000);
    check_output("new_game_state", game_state, 1);
    check_output("new_game_lives", lives, 3);
    check_output("new_game_score", score, 0);

    // Crossings until the score saturates.
    repeat (7) press(4'b1000);
    check_output("win_state", game_state, 3);
    check_output("win_score", score, 1);
    wait_state(1, 40, "win_to_play");
    check_output("win_respawn_row", frog_row, 7);
    for (int i = 0; i < 254; i++) do_win();
    check_output("score_255", score, 255);
    do_win();
    check_output("score_saturated", score, 255);

    // Reset in the middle of DYING.
    vert6 = 8'hFF;
    press(4'b1000);
    check_output("pre_reset_dying", game_state, 2);
    @(negedge clk);
    #3 reset = 1'b0;
    #1 check_reset_values("async_reset");
    wait_cycles(2);
    reset = 1'b1;
    vert6 = 8'h00;

    // Up and left in the same cycle: only the row moves.
    press(4'b1000);
    press(4'b1010);
    check_output("simul_row", frog_row, 6);
    check_output("simul_col", frog_col, 8'b0001_0000);

    // Random buttons, bounces, lanes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      vert1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      vert2 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      vert3 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      vert5 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      vert6 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 59) == 0) begin
        @(negedge clk);
        #3 reset = 1'b0;
        wait_cycles(1);
        reset = 1'b1;
      end
      apply_stimulus(4'($urandom_range(0, 15)), $urandom_range(1, 10), $urandom_range(1, 10));
    end

    wait_cycles(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
